nl_source_injector: RTL and testbench

NL_SOURCE_INJECTOR -- requirements
Module: nl_source_injector

---
 rtl/nl_source_injector.sv | 213 +++++++++++++++++++++
 tb/tb_nl_source_injector.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nl_source_injector.sv
// Source injector for a virtual-channel router input port.
// Pulls whole packets out of a source FIFO, allocates a free VC per packet
// (round-robin), and streams flits onto the router link under credit flow
// control. Flits without a head marker at packet start are dropped and
// flagged on the sticky err output.

module nl_source_injector #(
  parameter  int FLIT_W    = 64,
  parameter  int NUM_VC    = 2,
  parameter  int BUF_DEPTH = 4,
  localparam int VC_W      = $clog2(NUM_VC),
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] fifo_data,
  input  logic              fifo_head,
  input  logic              fifo_tail,
  output logic              fifo_pop,
  output logic              flit_valid,
  output logic [FLIT_W-1:0] flit_data,
  output logic [VC_W-1:0]   flit_vc,
  output logic              flit_head,
  output logic              flit_tail,
  input  logic              credit_valid,
  input  logic [VC_W-1:0]   credit_vc,
  output logic [31:0]       flits_sent,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  state_t                       state_q, state_d;
  logic [VC_W-1:0]              cur_vc_q, cur_vc_d;
  logic [VC_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_VC-1:0][CNT_W-1:0] credit_q, credit_d;
  logic                         flit_valid_q, flit_valid_d;
  logic [FLIT_W-1:0]            flit_data_q, flit_data_d;
  logic [VC_W-1:0]              flit_vc_q, flit_vc_d;
  logic                         flit_head_q, flit_head_d;
  logic                         flit_tail_q, flit_tail_d;
  logic [31:0]                  flits_sent_q, flits_sent_d;
  logic                         err_q, err_d;
  logic                         rst_hold_q, rst_hold_d;

  logic                         active;
  logic                         pop_send;
  logic                         pop_drop;
  logic [NUM_VC-1:0]            vc_free;
  logic [NUM_VC-1:0]            ret_vec;
  logic [NUM_VC-1:0]            snd_vec;
  logic                         bad_ret;
  logic                         alloc_found;
  logic [VC_W-1:0]              alloc_vc;

  // Pops are held off during reset and the cycle right after it, so an
  // abandoned packet cannot leak a flit across the reset boundary.
  always_comb begin
    active   = !rst && !rst_hold_q;
    pop_send = active && (state_q == SEND) && !fifo_empty && (credit_q[cur_vc_q] != '0);
    pop_drop = active && (state_q == IDLE) && !fifo_empty && !fifo_head;
    fifo_pop = pop_send || pop_drop;
  end

  // A VC is free only when its buffers are fully drained and no packet owns it.
  always_comb begin
    vc_free = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_free[v] = (credit_q[v] == FULL) && !((state_q == SEND) && (cur_vc_q == VC_W'(v)));
    end
  end

  // Round-robin search for a free VC, starting just after the last allocated one.
  always_comb begin
    int idx;
    idx         = 0;
    alloc_found = 1'b0;
    alloc_vc    = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(rr_ptr_q) + 1 + i) % NUM_VC;
      if (!alloc_found && vc_free[VC_W'(idx)]) begin
        alloc_found = 1'b1;
        alloc_vc    = VC_W'(idx);
      end
    end
  end

  // Classify credit returns (legal vs. overflow) and sends per VC.
  always_comb begin
    ret_vec = '0;
    snd_vec = '0;
    bad_ret = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (credit_valid && (credit_vc == VC_W'(v))) begin
        if (credit_q[v] == FULL) begin
          bad_ret = 1'b1;
        end else begin
          ret_vec[v] = 1'b1;
        end
      end
      snd_vec[v] = pop_send && (cur_vc_q == VC_W'(v));
    end
  end

  // Credit counters: a send and a return on the same VC cancel out.
  always_comb begin
    credit_d = credit_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (snd_vec[v] && !ret_vec[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (ret_vec[v] && !snd_vec[v]) begin
        credit_d[v] = credit_q[v] + 1'b1;
      end
    end
  end

  // Packet-level FSM: wait for a head flit, pick a VC, stream until tail.
  always_comb begin
    state_d  = state_q;
    cur_vc_d = cur_vc_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (active && !fifo_empty && fifo_head && (|vc_free)) begin
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        if (alloc_found) begin
          cur_vc_d = alloc_vc;
          rr_ptr_d = alloc_vc;
          state_d  = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (pop_send && fifo_tail) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Link output register: every send-pop appears on the link exactly one cycle later.
  always_comb begin
    flit_valid_d = pop_send;
    flit_data_d  = flit_data_q;
    flit_vc_d    = flit_vc_q;
    flit_head_d  = flit_head_q;
    flit_tail_d  = flit_tail_q;
    if (pop_send) begin
      flit_data_d = fifo_data;
      flit_vc_d   = cur_vc_q;
      flit_head_d = fifo_head;
      flit_tail_d = fifo_tail;
    end
    flits_sent_d = flits_sent_q + 32'(flit_valid_q);
    err_d        = err_q || pop_drop || bad_ret;
    rst_hold_d   = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_vc_q     <= '0;
      rr_ptr_q     <= VC_W'(NUM_VC - 1);
      credit_q     <= {NUM_VC{FULL}};
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
      flit_vc_q    <= '0;
      flit_head_q  <= 1'b0;
      flit_tail_q  <= 1'b0;
      flits_sent_q <= '0;
      err_q        <= 1'b0;
      rst_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_vc_q     <= cur_vc_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      flit_valid_q <= flit_valid_d;
      flit_data_q  <= flit_data_d;
      flit_vc_q    <= flit_vc_d;
      flit_head_q  <= flit_head_d;
      flit_tail_q  <= flit_tail_d;
      flits_sent_q <= flits_sent_d;
      err_q        <= err_d;
      rst_hold_q   <= rst_hold_d;
    end
  end

  // flit_valid is masked while rst is high so a flit popped just before reset is never presented.
  always_comb begin
    flit_valid = flit_valid_q && !rst;
    flit_data  = flit_data_q;
    flit_vc    = flit_vc_q;
    flit_head  = flit_head_q;
    flit_tail  = flit_tail_q;
    flits_sent = flits_sent_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_nl_source_injector.sv
// Directed testbench for nl_source_injector with a queue-based source FIFO model.

module tb_nl_source_injector;

  localparam int FLIT_W    = 64;
  localparam int NUM_VC    = 2;
  localparam int BUF_DEPTH = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        head;
    logic        tail;
  } flit_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [FLIT_W-1:0] fifo_data = '0;
  logic              fifo_head = 1'b0;
  logic              fifo_tail = 1'b0;
  logic              fifo_pop;
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_data;
  logic [0:0]        flit_vc;
  logic              flit_head;
  logic              flit_tail;
  logic              credit_valid = 1'b0;
  logic [0:0]        credit_vc = '0;
  logic [31:0]       flits_sent;
  logic              err;

  flit_t fifo_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  pop_seen;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  nl_source_injector #(
    .FLIT_W   (FLIT_W),
    .NUM_VC   (NUM_VC),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_head   (fifo_head),
    .fifo_tail   (fifo_tail),
    .fifo_pop    (fifo_pop),
    .flit_valid  (flit_valid),
    .flit_data   (flit_data),
    .flit_vc     (flit_vc),
    .flit_head   (flit_head),
    .flit_tail   (flit_tail),
    .credit_valid(credit_valid),
    .credit_vc   (credit_vc),
    .flits_sent  (flits_sent),
    .err         (err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refreshFifo();
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) begin
      fifo_data = fifo_q[0].data;
      fifo_head = fifo_q[0].head;
      fifo_tail = fifo_q[0].tail;
    end else begin
      fifo_data = '0;
      fifo_head = 1'b0;
      fifo_tail = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic head, input logic tail);
    flit_t f;
    f.data = data;
    f.head = head;
    f.tail = tail;
    fifo_q.push_back(f);
    refreshFifo();
  endtask

  task automatic pushPacket(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + 64'(i), (i == 0), (i == n - 1));
    end
  endtask

  // One clock cycle: sample the pop strobe before the edge, retire the FIFO head after it.
  task automatic step();
    #1;
    pop_seen = fifo_pop;
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() > 0) fifo_q.delete(0);
    refreshFifo();
    #1;
  endtask

  task automatic returnCredit(input logic [0:0] vc);
    credit_valid = 1'b1;
    credit_vc    = vc;
    step();
    credit_valid = 1'b0;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    credit_valid = 1'b0;
    fifo_q.delete();
    refreshFifo();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_flit_valid", 64'(flit_valid), 64'd0);
    checkOutput("rst_flit_data", flit_data, 64'd0);
    checkOutput("rst_flits_sent", 64'(flits_sent), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_credit0", 64'(dut.credit_q[0]), 64'd4);
    checkOutput("rst_credit1", 64'(dut.credit_q[1]), 64'd4);
    checkOutput("rst_state", 64'(dut.state_q), 64'd0);
    checkOutput("rst_pop", 64'(fifo_pop), 64'd0);

    // Single-flit packet: pop in cycle 2, flit on VC0 in cycle 3
    applyStimulus(64'h1100, 1'b1, 1'b1);
    #1;
    checkOutput("t1_c0_pop", 64'(fifo_pop), 64'd0);
    step();
    checkOutput("t1_c1_state", 64'(dut.state_q), 64'd1);
    checkOutput("t1_c1_pop", 64'(fifo_pop), 64'd0);
    step();
    checkOutput("t1_c2_pop", 64'(fifo_pop), 64'd1);
    checkOutput("t1_c2_valid", 64'(flit_valid), 64'd0);
    step();
    checkOutput("t1_c3_valid", 64'(flit_valid), 64'd1);
    checkOutput("t1_c3_data", flit_data, 64'h1100);
    checkOutput("t1_c3_vc", 64'(flit_vc), 64'd0);
    checkOutput("t1_c3_head", 64'(flit_head), 64'd1);
    checkOutput("t1_c3_tail", 64'(flit_tail), 64'd1);
    checkOutput("t1_c3_credit0", 64'(dut.credit_q[0]), 64'd3);
    step();
    checkOutput("t1_c4_valid", 64'(flit_valid), 64'd0);
    checkOutput("t1_c4_sent", 64'(flits_sent), 64'd1);
    returnCredit(1'b0);
    checkOutput("t1_credit0_back", 64'(dut.credit_q[0]), 64'd4);

    // 6-flit packet with only 4 credits: burst of 4, stall, then credit-paced
    doReset();
    pushPacket(6, 64'h2200);
    step();
    step();
    checkOutput("t2_c2_pop", 64'(fifo_pop), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("t2_burst%0d_valid", i), 64'(flit_valid), 64'd1);
      checkOutput($sformatf("t2_burst%0d_data", i), flit_data, 64'h2200 + 64'(i));
      checkOutput($sformatf("t2_burst%0d_head", i), 64'(flit_head), 64'(i == 0));
      checkOutput($sformatf("t2_burst%0d_vc", i), 64'(flit_vc), 64'd0);
    end
    checkOutput("t2_stall_pop", 64'(fifo_pop), 64'd0);
    checkOutput("t2_credit0_empty", 64'(dut.credit_q[0]), 64'd0);
    step();
    checkOutput("t2_c7_valid", 64'(flit_valid), 64'd0);
    step();
    checkOutput("t2_c8_valid", 64'(flit_valid), 64'd0);
    checkOutput("t2_c8_sent", 64'(flits_sent), 64'd4);
    returnCredit(1'b0);
    checkOutput("t2_c9_credit0", 64'(dut.credit_q[0]), 64'd1);
    checkOutput("t2_c9_pop", 64'(fifo_pop), 64'd1);
    checkOutput("t2_c9_valid", 64'(flit_valid), 64'd0);
    step();
    checkOutput("t2_c10_valid", 64'(flit_valid), 64'd1);
    checkOutput("t2_c10_data", flit_data, 64'h2204);
    returnCredit(1'b0);
    step();
    checkOutput("t2_last_valid", 64'(flit_valid), 64'd1);
    checkOutput("t2_last_data", flit_data, 64'h2205);
    checkOutput("t2_last_tail", 64'(flit_tail), 64'd1);
    checkOutput("t2_last_state", 64'(dut.state_q), 64'd0);
    for (int i = 0; i < 4; i++) returnCredit(1'b0);
    checkOutput("t2_credit0_full", 64'(dut.credit_q[0]), 64'd4);
    checkOutput("t2_err", 64'(err), 64'd0);

    // Back-to-back packets: VC0, then VC1, third waits for VC0 to drain
    doReset();
    pushPacket(2, 64'h3300);
    pushPacket(2, 64'h3310);
    pushPacket(1, 64'h3320);
    step();
    step();
    step();
    checkOutput("t3_a0_data", flit_data, 64'h3300);
    checkOutput("t3_a0_vc", 64'(flit_vc), 64'd0);
    step();
    checkOutput("t3_a1_data", flit_data, 64'h3301);
    checkOutput("t3_a1_tail", 64'(flit_tail), 64'd1);
    step();
    step();
    step();
    checkOutput("t3_b0_valid", 64'(flit_valid), 64'd1);
    checkOutput("t3_b0_data", flit_data, 64'h3310);
    checkOutput("t3_b0_vc", 64'(flit_vc), 64'd1);
    step();
    checkOutput("t3_b1_data", flit_data, 64'h3311);
    checkOutput("t3_b1_vc", 64'(flit_vc), 64'd1);
    checkOutput("t3_credit0", 64'(dut.credit_q[0]), 64'd2);
    checkOutput("t3_credit1", 64'(dut.credit_q[1]), 64'd2);
    step();
    checkOutput("t3_wait_state", 64'(dut.state_q), 64'd0);
    checkOutput("t3_wait_pop", 64'(fifo_pop), 64'd0);
    returnCredit(1'b1);
    checkOutput("t3_wait2_state", 64'(dut.state_q), 64'd0);
    returnCredit(1'b0);
    checkOutput("t3_wait3_state", 64'(dut.state_q), 64'd0);
    returnCredit(1'b0);
    checkOutput("t3_credit0_full", 64'(dut.credit_q[0]), 64'd4);
    step();
    checkOutput("t3_alloc_state", 64'(dut.state_q), 64'd1);
    step();
    checkOutput("t3_c_pop", 64'(fifo_pop), 64'd1);
    step();
    checkOutput("t3_c_valid", 64'(flit_valid), 64'd1);
    checkOutput("t3_c_data", flit_data, 64'h3320);
    checkOutput("t3_c_vc", 64'(flit_vc), 64'd0);
    checkOutput("t3_err", 64'(err), 64'd0);

    // Orphan body flit in IDLE is dropped and flags err
    applyStimulus(64'h3340, 1'b0, 1'b0);
    #1;
    checkOutput("t4_drop_pop", 64'(fifo_pop), 64'd1);
    step();
    checkOutput("t4_drop_valid", 64'(flit_valid), 64'd0);
    checkOutput("t4_err_set", 64'(err), 64'd1);
    checkOutput("t4_state", 64'(dut.state_q), 64'd0);
    step();
    checkOutput("t4_no_valid", 64'(flit_valid), 64'd0);
    step();
    checkOutput("t4_err_sticky", 64'(err), 64'd1);

    // Credit overflow on an idle VC
    doReset();
    checkOutput("t5_err_cleared", 64'(err), 64'd0);
    returnCredit(1'b1);
    checkOutput("t5_overflow_err", 64'(err), 64'd1);
    checkOutput("t5_overflow_credit1", 64'(dut.credit_q[1]), 64'd4);

    // Send and credit return on the same VC in one cycle
    doReset();
    pushPacket(2, 64'h3500);
    step();
    step();
    step();
    checkOutput("t5_c3_credit0", 64'(dut.credit_q[0]), 64'd3);
    checkOutput("t5_c3_pop", 64'(fifo_pop), 64'd1);
    returnCredit(1'b0);
    checkOutput("t5_c4_credit0", 64'(dut.credit_q[0]), 64'd3);
    checkOutput("t5_c4_data", flit_data, 64'h3501);
    checkOutput("t5_c4_err", 64'(err), 64'd0);

    // Reset in the middle of a 5-flit packet
    doReset();
    pushPacket(5, 64'h3600);
    step();
    step();
    step();
    step();
    checkOutput("t6_f1_valid", 64'(flit_valid), 64'd1);
    checkOutput("t6_f1_data", flit_data, 64'h3601);
    checkOutput("t6_sent_before", 64'(flits_sent), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_pop", 64'(fifo_pop), 64'd0);
    checkOutput("t6_rst_valid", 64'(flit_valid), 64'd0);
    fifo_q.delete();
    refreshFifo();
    step();
    rst = 1'b0;
    #1;
    checkOutput("t6_after_valid", 64'(flit_valid), 64'd0);
    checkOutput("t6_after_pop", 64'(fifo_pop), 64'd0);
    checkOutput("t6_after_data", flit_data, 64'd0);
    checkOutput("t6_after_vc", 64'(flit_vc), 64'd0);
    checkOutput("t6_after_head", 64'(flit_head), 64'd0);
    checkOutput("t6_after_tail", 64'(flit_tail), 64'd0);
    checkOutput("t6_after_sent", 64'(flits_sent), 64'd0);
    checkOutput("t6_after_err", 64'(err), 64'd0);
    checkOutput("t6_after_credit0", 64'(dut.credit_q[0]), 64'd4);
    checkOutput("t6_after_state", 64'(dut.state_q), 64'd0);
    step();
    checkOutput("t6_next_valid", 64'(flit_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
